// File: rtl/microcode_sequencer_if.sv
// Microcode sequencer bus.
// Groups the execution-driver strobes, the ROM word and the sequencer outputs.
//   master: driver/ROM side. It drives opcode, the load/enable strobes, the ROM
//           read enable and rom_data, and it observes the sequencer outputs.
//   slave : the sequencer.
interface microcode_sequencer_if #(
  parameter int unsigned OPCODE_WIDTH  = 6,
  parameter int unsigned STEP_WIDTH    = 4,
  parameter int unsigned CONTROL_WIDTH = 16
);
  logic [OPCODE_WIDTH-1:0]            opcode;
  logic                               microcode_sequencer_load_n;
  logic                               microcode_sequencer_enable;
  logic                               microcode_rom_read_enable;
  logic [CONTROL_WIDTH+1:0]           rom_data;
  logic [OPCODE_WIDTH+STEP_WIDTH-1:0] microcode_address;
  logic [CONTROL_WIDTH-1:0]           control_lines;
  logic                               instruction_finish_control_line;
  logic                               halt;
  logic                               step_fault;

  modport master (
    output opcode, microcode_sequencer_load_n, microcode_sequencer_enable,
           microcode_rom_read_enable, rom_data,
    input  microcode_address, control_lines, instruction_finish_control_line, halt, step_fault
  );

  modport slave (
    input  opcode, microcode_sequencer_load_n, microcode_sequencer_enable,
           microcode_rom_read_enable, rom_data,
    output microcode_address, control_lines, instruction_finish_control_line, halt, step_fault
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer.
// Latches an opcode and steps a microstep counter. The pair {opcode, step} addresses an
// external asynchronous-read ROM. The ROM word supplies the datapath control lines, a
// finish bit and a halt bit.
// Ports:
//   clock   : single clock; all state changes happen on its rising edge.
//   reset_n : synchronous, active-low reset. It overrides every other input.
//   bus     : microcode_sequencer_if.slave. It carries the opcode, the load_n and enable
//             strobes, the ROM read enable and rom_data. It returns microcode_address,
//             control_lines, instruction_finish_control_line, halt and step_fault.
module microcode_sequencer #(
  parameter int unsigned OPCODE_WIDTH  = 6,
  parameter int unsigned STEP_WIDTH    = 4,
  parameter int unsigned CONTROL_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  microcode_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoaded,
    StRunning,
    StFinished,
    StHalted
  } state_e;

  localparam logic [STEP_WIDTH-1:0] StepMax = '1;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    halt_q, halt_d;
  logic                    fault_q, fault_d;

  logic word_valid;
  logic finish_bit;
  logic halt_bit;
  logic finish_out;

  always_comb begin
    word_valid = bus.microcode_rom_read_enable &&
                 (state_q inside {StLoaded, StRunning, StFinished});
    finish_bit = bus.rom_data[CONTROL_WIDTH+1];
    halt_bit   = bus.rom_data[CONTROL_WIDTH];
    // FINISHED keeps the line up even when the held word no longer carries the finish
    // bit. An example is an instruction that stopped on a step fault.
    finish_out = (word_valid && finish_bit) || (state_q == StFinished);
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    halt_d   = halt_q;
    fault_d  = fault_q;

    if (word_valid && halt_bit) begin
      // A halt word wins over a load or an advance in the same cycle.
      halt_d  = 1'b1;
      state_d = StHalted;
    end else if ((state_q != StHalted) && !bus.microcode_sequencer_load_n) begin
      opcode_d = bus.opcode;
      step_d   = '0;
      state_d  = StLoaded;
    end else if (bus.microcode_sequencer_enable &&
                 (state_q == StLoaded || state_q == StRunning)) begin
      if (finish_out) begin
        state_d = StFinished;
      end else if (step_q != StepMax) begin
        step_d  = step_q + 1'b1;
        state_d = StRunning;
      end else begin
        // The counter ran off the end with no finish bit. Stop here instead of wrapping.
        fault_d = 1'b1;
        state_d = StFinished;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      step_q   <= '0;
      halt_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      halt_q   <= halt_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    bus.microcode_address               = {opcode_q, step_q};
    bus.control_lines                   = word_valid ? bus.rom_data[CONTROL_WIDTH-1:0] : '0;
    bus.instruction_finish_control_line = finish_out;
    bus.halt                            = halt_q;
    bus.step_fault                      = fault_q;
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed testbench for microcode_sequencer. The bench models a small ROM that is
// addressed by microcode_address, applies hand-written stimulus steps, and checks the
// outputs against constants.
module tb_microcode_sequencer;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  microcode_sequencer_if #(
    .OPCODE_WIDTH (6),
    .STEP_WIDTH   (4),
    .CONTROL_WIDTH(16)
  ) bus ();

  microcode_sequencer #(
    .OPCODE_WIDTH (6),
    .STEP_WIDTH   (4),
    .CONTROL_WIDTH(16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ROM word layout: {finish, halt, control[15:0]}.
  function automatic logic [17:0] rom_word(input logic [9:0] addr);
    logic [5:0]  op;
    logic [3:0]  st;
    logic [15:0] stx;
    op  = addr[9:4];
    st  = addr[3:0];
    stx = {12'h000, st};
    case (op)
      6'h05:   rom_word = (st == 4'd0) ? {2'b10, 16'h00A0} : 18'h0;
      6'h12:   rom_word = (st == 4'd3) ? {2'b10, 16'h12F3} : {2'b00, 16'h1200 | stx};
      6'h3F:   rom_word = {2'b00, 16'h3F00 | stx};
      6'h01:   rom_word = (st == 4'd1) ? {2'b01, 16'h0111} : {2'b00, 16'h0100};
      6'h07:   rom_word = {2'b00, 16'h0700 | stx};
      6'h09:   rom_word = {2'b00, 16'h0900 | stx};
      default: rom_word = 18'h0;
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.microcode_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.opcode                     = '0;
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b0;
    bus.microcode_rom_read_enable  = 1'b1;
    tick();
    tick();
    check("rst_addr",   32'(bus.microcode_address), 32'h000);
    check("rst_ctrl",   32'(bus.control_lines), 32'h0);
    check("rst_finish", 32'(bus.instruction_finish_control_line), 32'h0);
    check("rst_halt",   32'(bus.halt), 32'h0);
    check("rst_fault",  32'(bus.step_fault), 32'h0);

    // IDLE ignores enable.
    reset_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b1;
    tick();
    tick();
    check("idle_addr", 32'(bus.microcode_address), 32'h000);
    check("idle_ctrl", 32'(bus.control_lines), 32'h0);
    bus.microcode_sequencer_enable = 1'b0;

    // One-cycle instruction: finish is visible while LOADED, before any enable.
    bus.opcode = 6'h05;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    check("one_addr",   32'(bus.microcode_address), 32'h050);
    check("one_ctrl",   32'(bus.control_lines), 32'h00A0);
    check("one_finish", 32'(bus.instruction_finish_control_line), 32'h1);
    tick();
    check("one_hold_addr", 32'(bus.microcode_address), 32'h050);
    bus.microcode_rom_read_enable = 1'b0;
    #1;
    check("gate_ctrl",   32'(bus.control_lines), 32'h0);
    check("gate_finish", 32'(bus.instruction_finish_control_line), 32'h0);
    bus.microcode_rom_read_enable = 1'b1;

    // Four-step instruction that finishes at step 3.
    bus.opcode = 6'h12;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b1;
    #1;
    check("multi_a0", 32'(bus.microcode_address), 32'h120);
    check("multi_c0", 32'(bus.control_lines), 32'h1200);
    check("multi_f0", 32'(bus.instruction_finish_control_line), 32'h0);
    tick();
    check("multi_a1", 32'(bus.microcode_address), 32'h121);
    tick();
    check("multi_a2", 32'(bus.microcode_address), 32'h122);
    tick();
    check("multi_a3", 32'(bus.microcode_address), 32'h123);
    check("multi_c3", 32'(bus.control_lines), 32'h12F3);
    check("multi_f3", 32'(bus.instruction_finish_control_line), 32'h1);
    tick();
    check("fin_addr",   32'(bus.microcode_address), 32'h123);
    check("fin_finish", 32'(bus.instruction_finish_control_line), 32'h1);
    tick();
    check("fin_hold", 32'(bus.microcode_address), 32'h123);

    // Step overflow with no finish bit.
    bus.opcode = 6'h3F;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    repeat (15) tick();
    check("ovf_addr15", 32'(bus.microcode_address), 32'h3FF);
    check("ovf_nofault", 32'(bus.step_fault), 32'h0);
    check("ovf_nofin",  32'(bus.instruction_finish_control_line), 32'h0);
    tick();
    check("ovf_fault", 32'(bus.step_fault), 32'h1);
    check("ovf_fin",   32'(bus.instruction_finish_control_line), 32'h1);
    check("ovf_addr",  32'(bus.microcode_address), 32'h3FF);
    tick();
    check("ovf_nowrap", 32'(bus.microcode_address), 32'h3FF);

    // Reset in the middle of an instruction, then a fresh load.
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    tick();
    tick();
    check("mid_addr", 32'(bus.microcode_address), 32'h3F2);
    reset_n = 1'b0;
    tick();
    check("mid_rst_addr",   32'(bus.microcode_address), 32'h000);
    check("mid_rst_ctrl",   32'(bus.control_lines), 32'h0);
    check("mid_rst_finish", 32'(bus.instruction_finish_control_line), 32'h0);
    check("mid_rst_fault",  32'(bus.step_fault), 32'h0);
    check("mid_rst_halt",   32'(bus.halt), 32'h0);
    reset_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b0;
    bus.opcode = 6'h07;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    check("post_rst_addr", 32'(bus.microcode_address), 32'h070);
    check("post_rst_ctrl", 32'(bus.control_lines), 32'h0700);

    // A load and an enable on the same edge: the load wins.
    bus.opcode = 6'h3F;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b1;
    repeat (5) tick();
    check("prio_a5", 32'(bus.microcode_address), 32'h3F5);
    bus.opcode = 6'h09;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    check("prio_load", 32'(bus.microcode_address), 32'h090);
    check("prio_ctrl", 32'(bus.control_lines), 32'h0900);
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b0;
    tick();
    check("en0_hold", 32'(bus.microcode_address), 32'h090);

    // Halt word at step 1, with a load in the same cycle.
    bus.opcode = 6'h01;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b1;
    tick();
    check("hlt_pre_addr", 32'(bus.microcode_address), 32'h011);
    check("hlt_pre_ctrl", 32'(bus.control_lines), 32'h0111);
    check("hlt_pre_halt", 32'(bus.halt), 32'h0);
    bus.opcode = 6'h05;
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    check("hlt_halt",   32'(bus.halt), 32'h1);
    check("hlt_addr",   32'(bus.microcode_address), 32'h011);
    check("hlt_ctrl",   32'(bus.control_lines), 32'h0);
    check("hlt_finish", 32'(bus.instruction_finish_control_line), 32'h0);
    bus.microcode_sequencer_load_n = 1'b1;
    tick();
    check("hlt_en_addr", 32'(bus.microcode_address), 32'h011);
    check("hlt_sticky",  32'(bus.halt), 32'h1);
    bus.microcode_sequencer_load_n = 1'b0;
    tick();
    check("hlt_ld_addr", 32'(bus.microcode_address), 32'h011);
    reset_n = 1'b0;
    bus.microcode_sequencer_load_n = 1'b1;
    tick();
    check("hlt_rst_halt", 32'(bus.halt), 32'h0);
    check("hlt_rst_addr", 32'(bus.microcode_address), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 6, width of the opcode field latched from the current instruction.
REQ-002 Parameter STEP_WIDTH, default 4, width of the microstep counter; max step = 2^STEP_WIDTH-1.
REQ-003 Parameter CONTROL_WIDTH, default 16, number of datapath control lines per microcode word.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 opcode  input  OPCODE_WIDTH  opcode field of the current instruction.
REQ-007 microcode_sequencer_load_n  input  1  active-low load strobe from the execution driver.
REQ-008 microcode_sequencer_enable  input  1  microstep advance enable from the execution driver.
REQ-009 microcode_rom_read_enable  input  1  gates ROM word onto outputs.
REQ-010 rom_data  input  CONTROL_WIDTH+2  asynchronous-read ROM word: bit CONTROL_WIDTH+1 = finish, bit CONTROL_WIDTH = halt, low bits = control lines.
REQ-011 microcode_address  output  OPCODE_WIDTH+STEP_WIDTH  {opcode_reg, step}, driven from registers.
REQ-012 control_lines  output  CONTROL_WIDTH  gated control word.
REQ-013 instruction_finish_control_line  output  1  current instruction complete.
REQ-014 halt  output  1  sticky halt request to the execution driver.
REQ-015 step_fault  output  1  sticky: step counter hit max with no finish bit.

Function
REQ-016 States SHALL be IDLE, LOADED, RUNNING, FINISHED, HALTED; "word valid" = rom_read_enable=1 and state in {LOADED, RUNNING, FINISHED}.
REQ-017 control_lines SHALL equal rom_data[CONTROL_WIDTH-1:0] combinationally when word valid, else all zeros.
REQ-018 instruction_finish_control_line SHALL be (word valid AND rom_data finish bit) OR state==FINISHED, combinational, zero-cycle latency from address.
REQ-019 Any state except HALTED, load_n=0 at posedge: opcode_reg<=opcode, step<=0, state<=LOADED; load has priority over enable.
REQ-020 LOADED or RUNNING, enable=1, load_n=1, finish output 0, step<max: step<=step+1, state<=RUNNING.
REQ-021 LOADED or RUNNING, enable=1, load_n=1, finish output 1: step holds, state<=FINISHED.
REQ-022 RUNNING, enable=1, step==max, finish bit 0: step holds (no wrap), step_fault<=1, state<=FINISHED.
REQ-023 enable=0 with load_n=1: step and state hold in every state.
REQ-024 FINISHED: step holds; leaves only via load_n=0 (REQ-019) or halt (REQ-025).
REQ-025 Word valid AND rom_data halt bit =1 at posedge: halt<=1, state<=HALTED; halt takes priority over load_n and enable in the same cycle.
REQ-026 HALTED: load_n and enable ignored, control_lines=0, instruction_finish_control_line=0, halt and step_fault held until reset.
REQ-027 IDLE: enable ignored, outputs zero, microcode_address={opcode_reg, step}.
REQ-028 1-cycle instructions: finish bit at step 0 SHALL assert instruction_finish_control_line while LOADED, before any enable.

Reset
REQ-029 reset_n=0 at posedge SHALL set state=IDLE, opcode_reg=0, step=0, halt=0, step_fault=0, with priority over all other inputs including mid-instruction and HALTED.
REQ-030 During and after reset: microcode_address=0, control_lines=0, instruction_finish_control_line=0.

Verification
REQ-031 opcode=0x05, load_n=0 one cycle, read_enable=1, ROM[0x05,0] finish=1 control=0x00A0 -> address 0x050, control_lines 0x00A0, finish 1 in LOADED without enable.
REQ-032 opcode=0x12, ROM steps 0..2 no finish, step 3 finish; enable=1 -> address 0x120,0x121,0x122,0x123; finish at step 3; state FINISHED, step holds 3.
REQ-033 opcode=0x3F, no finish bit in any step, enable=1 -> step reaches 15, step_fault=1, finish=1, step stays 15.
REQ-034 ROM[0x01,1] halt=1, enable=1, load_n=0 in halt cycle -> halt=1, HALTED, further load_n/enable ignored, control_lines 0.
REQ-035 Reset asserted at step 2 of running instruction -> next cycle state IDLE, address 0, all outputs 0; then load_n=0 opcode 0x07 -> address 0x070.
REQ-036 load_n=0 and enable=1 same posedge at step 5 -> step=0, new opcode latched, no increment.
